fetch_unit: RTL and testbench

- Instruction-fetch (IF) stage and IF/ID pipeline register for the 5-stage pipelined CPU.
- Consumes the control unit's hold request (wpcir) and redirect (cu_branch + target).
- Drives a req/ack instruction-memory handshake and supplies if_instr (IF-stage look-ahead for load-use detection) and id_instr to decode.
- Tolerates variable memory latency; sustains one instruction per cycle when imem_ack returns in the request cycle.

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_unit_if_id_reg.sv | 33 +++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W_DEFAULT = 32;

  localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0000;
  localparam logic [ADDR_W_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: loads a fetched word or inserts a bubble (bubble keeps pc4).
module fetch_unit_if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic [ADDR_W-1:0]  pc4_d,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc4,
  output logic               id_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_instr <= INSTR_NOP;
      id_pc4   <= '0;
      id_valid <= 1'b0;
    end else if (bubble) begin
      id_instr <= INSTR_NOP;
      id_valid <= 1'b0;
    end else if (load) begin
      id_instr <= instr_d;
      id_pc4   <= pc4_d;
      id_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC, req/ack fetch FSM with one-word fetch buffer, feeding the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned        ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wpcir,
  input  logic               cu_branch,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc4,
  output logic               id_valid
);

  fetch_state_e       state, state_nxt;
  logic [ADDR_W-1:0]  pc_nxt, pc_plus4, req_addr;
  logic [INSTR_W-1:0] fb, fb_nxt;
  logic               fb_valid, fb_valid_nxt;
  logic               fetch_ack, avail;
  logic               id_load, id_bubble;

  assign pc_plus4  = pc + ADDR_W'(4);
  assign fetch_ack = (state == S_FETCH) && imem_ack;
  assign avail     = fb_valid || fetch_ack;

  // Request is a decode of state so reset drops it immediately; address comes from a latch
  // so a redirect during an outstanding fetch cannot disturb it.
  assign imem_req  = (state == S_FETCH) || (state == S_DRAIN);
  assign imem_addr = req_addr;
  assign if_valid  = avail;
  assign if_instr  = fb_valid ? fb : (fetch_ack ? imem_rdata : INSTR_NOP);

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    fb_nxt       = fb;
    fb_valid_nxt = fb_valid;
    id_load      = 1'b0;
    id_bubble    = 1'b0;
    if (cu_branch) begin
      pc_nxt       = branch_target;
      fb_valid_nxt = 1'b0;
      id_bubble    = 1'b1;
      case (state)
        S_FETCH, S_DRAIN: state_nxt = imem_ack ? S_FETCH : S_DRAIN;
        default:          state_nxt = S_FETCH;
      endcase
    end else if (wpcir) begin
      if (avail) begin
        id_load      = 1'b1;
        pc_nxt       = pc_plus4;
        fb_valid_nxt = 1'b0;
        state_nxt    = S_FETCH;
      end else begin
        id_bubble = 1'b1;
        state_nxt = ((state == S_DRAIN) && !imem_ack) ? S_DRAIN : S_FETCH;
      end
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_FETCH;
        S_FETCH: begin
          if (imem_ack) begin
            fb_nxt       = imem_rdata;
            fb_valid_nxt = 1'b1;
            state_nxt    = S_HOLD;
          end
        end
        S_DRAIN: begin
          if (imem_ack) state_nxt = S_FETCH;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      fb       <= INSTR_NOP;
      fb_valid <= 1'b0;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      fb       <= fb_nxt;
      fb_valid <= fb_valid_nxt;
      if (state_nxt == S_FETCH) req_addr <= pc_nxt;
    end
  end

  fetch_unit_if_id_reg #(
    .ADDR_W(ADDR_W)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load     (id_load),
    .bubble   (id_bubble),
    .instr_d  (fb_valid ? fb : imem_rdata),
    .pc4_d    (pc_plus4),
    .id_instr (id_instr),
    .id_pc4   (id_pc4),
    .id_valid (id_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected IF/ID writes are queued by the stimulus and popped by a monitor.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        wpcir;
  logic        cu_branch;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } id_exp_t;

  id_exp_t     exp_q[$];
  id_exp_t     mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned mem_wait = 0;
  int unsigned wcnt;
  int          req10 = 0;
  logic        wr_flag = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W  (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wpcir        (wpcir),
    .cu_branch    (cu_branch),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .if_instr     (if_instr),
    .if_valid     (if_valid),
    .id_instr     (id_instr),
    .id_pc4       (id_pc4),
    .id_valid     (id_valid)
  );

  // Memory model: acks after mem_wait stall cycles; word = C0DE_<addr[15:0]>.
  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  assign imem_ack   = imem_req && (wcnt >= mem_wait);
  assign imem_rdata = 32'hC0DE_0000 | {16'h0000, imem_addr[15:0]};

  always @(posedge clk) begin
    if (!rst && imem_req && imem_ack && imem_addr == 32'h10) req10 <= req10 + 1;
    wr_flag <= !rst && (wpcir || cu_branch);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic v, input logic [31:0] i, input logic [31:0] p4);
    id_exp_t e;
    e.valid = v;
    e.instr = i;
    e.pc4   = p4;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wpcir = 1'b1; cu_branch = 1'b0; branch_target = '0; mem_wait = 0;
    fork
      forever begin
        @(negedge clk);
        if (wr_flag) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL id_write: unexpected IF/ID write, id_instr %h id_valid %0d", id_instr, id_valid);
          end else begin
            mon_e = exp_q.pop_front();
            chk("id_valid", 32'(id_valid), 32'(mon_e.valid));
            chk("id_instr", id_instr, mon_e.instr);
            if (mon_e.valid) chk("id_pc4", id_pc4, mon_e.pc4);
          end
        end
      end
      begin
        @(negedge clk); @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc4", id_pc4, 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);

        // Zero-wait streaming
        rst = 1'b0; push(1'b0, 32'h0, 32'h0); tick();
        chk("s_addr0", imem_addr, 32'h0);
        chk("s_req0", 32'(imem_req), 32'd1);
        chk("s_if_valid0", 32'(if_valid), 32'd1);
        chk("s_if_instr0", if_instr, 32'hC0DE_0000);
        push(1'b1, 32'hC0DE_0000, 32'h4); tick();
        chk("s_pc4", pc, 32'h4);
        chk("s_addr4", imem_addr, 32'h4);
        push(1'b1, 32'hC0DE_0004, 32'h8); tick();
        chk("s_addr8", imem_addr, 32'h8);
        push(1'b1, 32'hC0DE_0008, 32'hC); tick();
        push(1'b1, 32'hC0DE_000C, 32'h10); tick();
        chk("s_pc10", pc, 32'h10);
        chk("s_addr10", imem_addr, 32'h10);

        // Hold three cycles at pc 0x10
        wpcir = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          chk("h_req", 32'(imem_req), 32'd0);
          chk("h_pc", pc, 32'h10);
          chk("h_id_instr", id_instr, 32'hC0DE_000C);
          chk("h_id_pc4", id_pc4, 32'h10);
          chk("h_if_instr", if_instr, 32'hC0DE_0010);
        end
        wpcir = 1'b1; push(1'b1, 32'hC0DE_0010, 32'h14); tick();
        chk("h_req10_count", 32'(req10), 32'd1);
        chk("h_pc14", pc, 32'h14);
        chk("h_addr14", imem_addr, 32'h14);

        // Two wait cycles -> two bubbles, address stable
        mem_wait = 2; push(1'b0, 32'h0, 32'h0); tick();
        chk("w_addr1", imem_addr, 32'h14);
        chk("w_ack1", 32'(imem_ack), 32'd0);
        push(1'b0, 32'h0, 32'h0); tick();
        chk("w_addr2", imem_addr, 32'h14);
        chk("w_ack2", 32'(imem_ack), 32'd1);
        push(1'b1, 32'hC0DE_0014, 32'h18); tick();
        chk("w_pc18", pc, 32'h18);
        chk("w_addr18", imem_addr, 32'h18);

        // Redirect to 0x40 while fetch to 0x18 outstanding
        cu_branch = 1'b1; branch_target = 32'h40; push(1'b0, 32'h0, 32'h0); tick();
        chk("d_pc40", pc, 32'h40);
        chk("d_addr_hold1", imem_addr, 32'h18);
        chk("d_req", 32'(imem_req), 32'd1);
        cu_branch = 1'b0; push(1'b0, 32'h0, 32'h0); tick();
        chk("d_addr_hold2", imem_addr, 32'h18);
        chk("d_ack", 32'(imem_ack), 32'd1);
        push(1'b0, 32'h0, 32'h0); tick();
        chk("d_addr40", imem_addr, 32'h40);
        mem_wait = 0; push(1'b1, 32'hC0DE_0040, 32'h44); tick();
        chk("d_pc44", pc, 32'h44);

        // Redirect together with hold: redirect wins
        cu_branch = 1'b1; wpcir = 1'b0; branch_target = 32'h100; push(1'b0, 32'h0, 32'h0); tick();
        chk("b_pc100", pc, 32'h100);
        chk("b_addr100", imem_addr, 32'h100);
        chk("b_id_pc4_kept", id_pc4, 32'h44);
        cu_branch = 1'b0; wpcir = 1'b1; push(1'b1, 32'hC0DE_0100, 32'h104); tick();
        chk("b_pc104", pc, 32'h104);

        // Reset during an outstanding request at 0x80
        cu_branch = 1'b1; branch_target = 32'h80; push(1'b0, 32'h0, 32'h0); tick();
        cu_branch = 1'b0; mem_wait = 5;
        chk("r_pc80", pc, 32'h80);
        chk("r_addr80", imem_addr, 32'h80);
        chk("r_req80", 32'(imem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("r_req_async", 32'(imem_req), 32'd0);
        chk("r_pc_async", pc, 32'h0);
        @(negedge clk);
        mem_wait = 0; rst = 1'b0; push(1'b0, 32'h0, 32'h0); tick();
        chk("r_addr0", imem_addr, 32'h0);
        chk("r_req0", 32'(imem_req), 32'd1);
        push(1'b1, 32'hC0DE_0000, 32'h4); tick();
        chk("r_pc4", pc, 32'h4);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
      end
    join
  end

endmodule
